chnl_tx_arb: RTL

//   Multi-source buffered Riffa/CHNL transmitter: N_SRC independent input streams, each with its
//   own FIFO and queue counter, share one CHNL TX channel. A round-robin arbiter picks an eligible

---
 rtl/chnl_pkg.sv | 24 ++
 rtl/chnl_rr_arb.sv | 35 +++
 rtl/fifo.sv | 50 +++++
 rtl/chnl_tx_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/chnl_pkg.sv
// chnl_pkg: shared types and constants for the multi-source CHNL TX arbiter.
//   - state_t      : transaction FSM states
//   - SRC_W        : width of the source id field (header and o_src)
//   - hdr_word()   : builds the low 32 bits of the header beat
package chnl_pkg;

    localparam int SRC_W       = 4;
    localparam int HDR_SRC_LSB = 0;
    localparam int HDR_LEN_LSB = 8;
    localparam int HDR_LEN_W   = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HDR,
        S_DATA
    } state_t;

    // Header layout: [31:8] payload length in uint32, [7:4] zero, [3:0] source id.
    function automatic logic [31:0] hdr_word(input logic [HDR_LEN_W-1:0] len,
                                             input logic [SRC_W-1:0]     src);
        return {len, 4'b0000, src};
    endfunction

endpackage

// File: rtl/chnl_rr_arb.sv
// chnl_rr_arb: combinational round-robin picker.
//   i_req  : per-source request vector
//   i_ptr  : highest-priority source index this round
//   o_gnt  : one-hot grant (lowest index at or after i_ptr, wrapping)
//   o_idx  : index of the granted source
//   o_any  : at least one request present
module chnl_rr_arb
    import chnl_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [SRC_W-1:0] i_ptr,
    output logic [N_SRC-1:0] o_gnt,
    output logic [SRC_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            j = (int'(i_ptr) + k) % N_SRC;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = SRC_W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo.sv
// fifo: synchronous first-word-fall-through FIFO.
//   clk, rst           : clock, async active-high reset (clears pointers)
//   i_wr_en/i_wr_data  : write side, ignored when o_full
//   i_rd_en/o_rd_data  : read side, o_rd_data shows the head while !o_empty
//   o_full, o_empty    : status
// DEPTH must be a power of two (pointers carry one extra wrap bit).
module fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/chnl_tx_arb.sv
// chnl_tx_arb: N_SRC buffered input streams sharing one Riffa CHNL TX channel.
//   clk, rst            : clock, async active-high reset
//   i_val/i_rdy/i_data  : per-source stream input, source s at i_data[s*W +: W]
//   i_flush             : per-source pulse, send the aligned part of what is queued
//   CHNL_TX_*           : Riffa TX channel (ACK is not needed for control)
//   o_src               : source id of the current / last transaction
// Each source owns a FIFO plus a queue counter and idle counter; a round-robin
// arbiter picks one eligible source per transaction, optionally preceded by a
// one-beat header carrying source id and payload length.
module chnl_tx_arb
    import chnl_pkg::*;
#(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int N_SRC            = 4,
    parameter int CHNL_ALIGN       = 1,
    parameter int MAX_LENGTH       = 32,
    parameter int MAX_IDLE_CYCLES  = 128,
    parameter int HDR_EN           = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SRC-1:0]              i_val,
    output logic [N_SRC-1:0]              i_rdy,
    input  logic [N_SRC*C_PCI_DATA_WIDTH-1:0] i_data,
    input  logic [N_SRC-1:0]              i_flush,
    output logic                          CHNL_TX_CLK,
    output logic                          CHNL_TX,
    input  logic                          CHNL_TX_ACK,
    output logic                          CHNL_TX_LAST,
    output logic [31:0]                   CHNL_TX_LEN,
    output logic [30:0]                   CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0]   CHNL_TX_DATA,
    output logic                          CHNL_TX_DATA_VALID,
    input  logic                          CHNL_TX_DATA_REN,
    output logic [SRC_W-1:0]              o_src
);

    localparam int          W           = C_PCI_DATA_WIDTH;
    localparam logic [31:0] WPB         = 32'(W / 32);
    localparam logic [31:0] ALIGN_BEATS = 32'((32 * CHNL_ALIGN) / W);
    localparam logic [31:0] MAX_BEATS   = 32'((MAX_LENGTH * 32) / W);
    localparam logic [31:0] IDLE_SAT    = 32'(MAX_IDLE_CYCLES);
    localparam bit          TIMEOUT_EN  = (MAX_IDLE_CYCLES != 0);
    localparam logic [31:0] HDR_BEATS   = (HDR_EN != 0) ? 32'd1 : 32'd0;
    // Deep enough that a source can fill a whole transaction while another one drains.
    localparam int          FIFO_DEPTH  = 1 << $clog2(2 * MAX_BEATS);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [SRC_W-1:0]            r_src;
    logic [SRC_W-1:0]            r_ptr;
    logic [31:0]                 r_cnt_left;
    logic [31:0]                 r_len;

    logic [31:0]                 r_cnt_q      [N_SRC];
    logic [31:0]                 r_idle       [N_SRC];
    logic                        r_flush_pend [N_SRC];

    logic [N_SRC-1:0]            w_enq;
    logic [N_SRC-1:0]            w_deq;
    logic [N_SRC-1:0]            w_full;
    logic [N_SRC-1:0]            w_empty;
    logic [N_SRC-1:0]            w_elig;
    logic [N_SRC-1:0][W-1:0]     w_fifo_data;

    logic [N_SRC-1:0]            w_arb_gnt;
    logic [SRC_W-1:0]            w_arb_idx;
    logic                        w_arb_any;
    logic                        w_grant;
    logic                        w_pop;
    logic [W-1:0]                w_sel_data;
    logic                        w_sel_empty;
    logic [31:0]                 w_gnt_cnt;
    logic [31:0]                 w_gnt_min;
    logic [31:0]                 w_gnt_len;
    logic [W-1:0]                w_hdr;
    logic                        w_unused;

    assign w_unused = CHNL_TX_ACK;

    // ---------------- per-source buffering and bookkeeping ----------------
    for (genvar s = 0; s < N_SRC; s++) begin : g_src
        logic [31:0] w_cnt_nxt;

        fifo #(
            .WIDTH (W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_enq[s]),
            .i_wr_data (i_data[s*W +: W]),
            .o_full    (w_full[s]),
            .i_rd_en   (w_deq[s]),
            .o_rd_data (w_fifo_data[s]),
            .o_empty   (w_empty[s])
        );

        assign i_rdy[s] = !w_full[s];
        assign w_enq[s] = i_val[s] && !w_full[s];
        assign w_deq[s] = w_pop && (r_src == SRC_W'(s));

        always_comb begin
            w_cnt_nxt = r_cnt_q[s];
            if (w_enq[s] && !w_deq[s])      w_cnt_nxt = r_cnt_q[s] + 32'd1;
            else if (!w_enq[s] && w_deq[s]) w_cnt_nxt = r_cnt_q[s] - 32'd1;
        end

        assign w_elig[s] = (r_cnt_q[s] >= MAX_BEATS) ||
                           ((r_cnt_q[s] >= ALIGN_BEATS) &&
                            ((TIMEOUT_EN && (r_idle[s] >= IDLE_SAT)) || r_flush_pend[s]));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt_q[s]      <= '0;
                r_idle[s]       <= '0;
                r_flush_pend[s] <= 1'b0;
            end else begin
                r_cnt_q[s] <= w_cnt_nxt;
                if (w_enq[s])
                    r_idle[s] <= '0;
                else if (!i_val[s] && (r_idle[s] < IDLE_SAT))
                    r_idle[s] <= r_idle[s] + 32'd1;
                // A flush with less than one aligned unit queued is simply dropped.
                r_flush_pend[s] <= (r_flush_pend[s] || i_flush[s]) &&
                                   !(w_grant && w_arb_gnt[s]) &&
                                   (w_cnt_nxt >= ALIGN_BEATS);
            end
        end
    end

    // ---------------- arbitration ----------------
    chnl_rr_arb #(
        .N_SRC (N_SRC)
    ) u_arb (
        .i_req (w_elig),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    always_comb begin
        w_sel_data  = '0;
        w_sel_empty = 1'b1;
        w_gnt_cnt   = '0;
        for (int s = 0; s < N_SRC; s++) begin
            if (r_src == SRC_W'(s)) begin
                w_sel_data  = w_fifo_data[s];
                w_sel_empty = w_empty[s];
            end
            if (w_arb_gnt[s]) w_gnt_cnt = r_cnt_q[s];
        end
    end

    // Transaction length: capped at one max transfer, trimmed to the alignment unit.
    assign w_gnt_min = (w_gnt_cnt > MAX_BEATS) ? MAX_BEATS : w_gnt_cnt;
    assign w_gnt_len = w_gnt_min - (w_gnt_min % ALIGN_BEATS);

    // ---------------- transaction FSM ----------------
    always_comb begin
        w_state_nxt        = r_state;
        w_grant            = 1'b0;
        w_pop              = 1'b0;
        CHNL_TX_DATA_VALID = 1'b0;
        w_hdr              = '0;
        w_hdr[31:0]        = hdr_word(24'(r_cnt_left * WPB), r_src);
        CHNL_TX_DATA       = w_sel_data;
        case (r_state)
            S_IDLE: begin
                if (w_arb_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = (HDR_EN != 0) ? S_HDR : S_DATA;
                end
            end
            S_HDR: begin
                CHNL_TX_DATA_VALID = 1'b1;
                CHNL_TX_DATA       = w_hdr;
                if (CHNL_TX_DATA_REN) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                CHNL_TX_DATA_VALID = !w_sel_empty;
                w_pop              = !w_sel_empty && CHNL_TX_DATA_REN;
                if (w_pop && (r_cnt_left == 32'd1)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_ptr      <= '0;
            r_cnt_left <= '0;
            r_len      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_src      <= w_arb_idx;
                r_cnt_left <= w_gnt_len;
                r_len      <= (w_gnt_len + HDR_BEATS) * WPB;
                r_ptr      <= (w_arb_idx == SRC_W'(N_SRC - 1)) ? '0 : w_arb_idx + SRC_W'(1);
            end else if (w_pop) begin
                r_cnt_left <= r_cnt_left - 32'd1;
            end
        end
    end

    assign CHNL_TX_CLK  = clk;
    assign CHNL_TX      = (r_state != S_IDLE);
    assign CHNL_TX_LAST = 1'b1;
    assign CHNL_TX_LEN  = r_len;
    assign CHNL_TX_OFF  = '0;
    assign o_src        = r_src;

endmodule
